// File: rtl/muldiv_pkg.sv
// Shared ALU_OP codes, FSM state encoding and special-case results for the RV32M mul/div unit.
package muldiv_pkg;

  localparam int unsigned OP_W  = 5;
  localparam int unsigned XLEN  = 32;

  localparam logic [OP_W-1:0] OP_MUL    = 5'b10000;
  localparam logic [OP_W-1:0] OP_MULH   = 5'b10001;
  localparam logic [OP_W-1:0] OP_MULHSU = 5'b10010;
  localparam logic [OP_W-1:0] OP_MULHU  = 5'b10011;
  localparam logic [OP_W-1:0] OP_DIV    = 5'b10100;
  localparam logic [OP_W-1:0] OP_DIVU   = 5'b10101;
  localparam logic [OP_W-1:0] OP_REM    = 5'b10110;
  localparam logic [OP_W-1:0] OP_REMU   = 5'b10111;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] OVF_Q      = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage handshake between ID/EX, the mul/div unit and the result/stall consumers.
interface ex_muldiv_unit_if #(parameter int unsigned WIDTH = 32);

  logic             IN_VALID;
  logic [4:0]       IN_ALU_OP;
  logic [WIDTH-1:0] IN_DATA1;
  logic [WIDTH-1:0] IN_DATA2;
  logic             IN_HOLD;
  logic [WIDTH-1:0] OUT_RESULT;
  logic             OUT_DONE;
  logic             OUT_BUSYWAIT;

  modport master (
    output IN_VALID, IN_ALU_OP, IN_DATA1, IN_DATA2, IN_HOLD,
    input  OUT_RESULT, OUT_DONE, OUT_BUSYWAIT
  );

  modport slave (
    input  IN_VALID, IN_ALU_OP, IN_DATA1, IN_DATA2, IN_HOLD,
    output OUT_RESULT, OUT_DONE, OUT_BUSYWAIT
  );

endinterface

// File: rtl/div_iter_core.sv
// Restoring unsigned divider datapath: one quotient bit per step, counter 0..WIDTH-1.
// Exposes the post-step quotient/remainder so the caller can finish on the last step's edge.
module div_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_c,
  output logic [WIDTH-1:0] rem_c,
  output logic             last_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  always_comb begin
    trial  = {rem_q, quo_q[WIDTH-1]};
    diff   = trial - {1'b0, dsr_q};
    quo_c  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    rem_c  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    last_c = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    cnt_d = cnt_q;
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dsr_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      quo_d = quo_c;
      rem_d = rem_c;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage; stalls upstream via OUT_BUSYWAIT.
// Optional: define MULDIV_DIV_EARLY_EXIT_EN to finish divides with |rs2| > |rs1| in one cycle.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic               CLK,
  input logic               RESET,
  ex_muldiv_unit_if.slave   bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic signed [WIDTH:0] a_q, a_d;
  logic signed [WIDTH:0] b_q, b_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                done_q, done_d;

  logic                div_load_c, div_step_c, div_last_c;
  logic [WIDTH-1:0]    div_quo_c, div_rem_c;
  logic [WIDTH-1:0]    rs1_c, rs2_c, mag1_c, mag2_c;
  logic                sgn_div_c, is_rem_c;
  logic signed [PW-1:0] prod_c;

  // Operand views for accept-time decisions.
  always_comb begin
    rs1_c     = bus.IN_DATA1;
    rs2_c     = bus.IN_DATA2;
    sgn_div_c = ~bus.IN_ALU_OP[0];
    is_rem_c  = bus.IN_ALU_OP[1];
    mag1_c    = (sgn_div_c && rs1_c[WIDTH-1]) ? (~rs1_c + WIDTH'(1)) : rs1_c;
    mag2_c    = (sgn_div_c && rs2_c[WIDTH-1]) ? (~rs2_c + WIDTH'(1)) : rs2_c;
    prod_c    = PW'(a_q) * PW'(b_q);
  end

  div_iter_core #(.WIDTH(WIDTH)) u_div (
    .clk      (CLK),
    .rst      (RESET),
    .load     (div_load_c),
    .step     (div_step_c),
    .dividend (mag1_c),
    .divisor  (mag2_c),
    .quo_c    (div_quo_c),
    .rem_c    (div_rem_c),
    .last_c   (div_last_c)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    result_d   = result_q;
    done_d     = done_q;
    div_load_c = 1'b0;
    div_step_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.IN_VALID && bus.IN_ALU_OP[4]) begin
          op_d = bus.IN_ALU_OP;
          if (!bus.IN_ALU_OP[2]) begin
            // MULH: both signed; MULHSU: rs1 signed only; MULHU/MUL: zero-extend.
            a_d     = (bus.IN_ALU_OP[1:0] == 2'b01 || bus.IN_ALU_OP[1:0] == 2'b10)
                      ? {rs1_c[WIDTH-1], rs1_c} : {1'b0, rs1_c};
            b_d     = (bus.IN_ALU_OP[1:0] == 2'b01) ? {rs2_c[WIDTH-1], rs2_c} : {1'b0, rs2_c};
            state_d = ST_MUL;
          end else if (rs2_c == '0) begin
            result_d = is_rem_c ? rs1_c : WIDTH'(DIV_ZERO_Q);
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end else if (sgn_div_c && rs1_c == MIN_NEG && rs2_c == '1) begin
            result_d = is_rem_c ? '0 : WIDTH'(OVF_Q);
            done_d   = 1'b1;
            state_d  = ST_DONE;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
          end else if (mag2_c > mag1_c) begin
            result_d = is_rem_c ? rs1_c : '0;
            done_d   = 1'b1;
            state_d  = ST_DONE;
`endif
          end else begin
            div_load_c = 1'b1;
            q_neg_d    = sgn_div_c & (rs1_c[WIDTH-1] ^ rs2_c[WIDTH-1]);
            r_neg_d    = sgn_div_c & rs1_c[WIDTH-1];
            state_d    = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        result_d = (op_q == OP_MUL) ? prod_c[WIDTH-1:0] : prod_c[PW-1:WIDTH];
        done_d   = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DIV: begin
        div_step_c = 1'b1;
        if (div_last_c) begin
          if (op_q[1]) result_d = r_neg_q ? (~div_rem_c + WIDTH'(1)) : div_rem_c;
          else         result_d = q_neg_q ? (~div_quo_c + WIDTH'(1)) : div_quo_c;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.IN_HOLD) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.OUT_RESULT   = result_q;
  assign bus.OUT_DONE     = done_q;
  assign bus.OUT_BUSYWAIT = ~RESET & (((state_q == ST_IDLE) & bus.IN_VALID & bus.IN_ALU_OP[4])
                                      | (state_q == ST_MUL) | (state_q == ST_DIV));

endmodule
